inst_mem_loader: RTL and testbench

- Write side of the instruction memory: a 32-word writable instruction store with a byte-stream load port.
- Assembles incoming bytes into 32-bit instruction words and writes them sequentially from word 0.
- Serves the fetch stage through the same pc-in / inst-out read interface, so programs are loaded at run time rather than hard-coded.
- Holds the CPU off (cpu_hold) while a load is in progress.

---
 rtl/inst_mem_loader.sv | 149 ++++++++++++++
 tb/tb_inst_mem_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Writable 32-word instruction store with a byte-stream load port.
// Incoming bytes are packed little-endian into 32-bit words and written
// sequentially from word 0. The fetch stage reads through a combinational
// pc -> inst port. cpu_hold stalls the pipeline while a load is in progress.
module inst_mem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [31:0]       pc,
    output logic [31:0]       inst,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_len
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    logic [31:0]         r_mem [DEPTH];
    logic                r_byte_ready;
    logic                r_cpu_hold;
    logic                r_load_done;
    logic                r_err_len;
    logic [ADDR_W:0]     r_word_count;
    logic [ADDR_W:0]     r_eff_len;
    logic [1:0]          r_lane;
    logic [23:0]         r_partial;

    logic [ADDR_W:0]     w_eff_len;
    logic                w_xfer;
    logic                w_last_lane;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [31:0]         w_wr_data;
    logic [ADDR_W:0]     w_wc_inc;
    logic [ADDR_W-1:0]   w_rd_idx;
    logic                w_out_range;
    logic                w_unused_pc;

    // Requests larger than the store are clamped; err_len records the clamp.
    assign w_eff_len   = (load_len > DEPTH_L) ? DEPTH_L : load_len;
    // load_start wins over a byte arriving in the same cycle.
    assign w_xfer      = (r_state == S_LOAD) && r_byte_ready && byte_valid && !load_start;
    assign w_last_lane = (r_lane == 2'd3);
    assign w_wr_en     = w_xfer && w_last_lane;
    // In LOAD word_count is always below eff_len <= DEPTH, so the low bits index safely.
    assign w_wr_addr   = r_word_count[ADDR_W-1:0];
    assign w_wr_data   = {byte_in, r_partial};
    assign w_wc_inc    = r_word_count + (ADDR_W + 1)'(1);

    assign w_rd_idx    = pc[ADDR_W+1:2];
    assign w_out_range = |pc[31:ADDR_W+2];
    // Byte offset within the word does not select anything.
    assign w_unused_pc = ^pc[1:0];

    // Load sequencer: lane counting, word assembly, status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_byte_ready <= 1'b0;
            r_cpu_hold   <= 1'b0;
            r_load_done  <= 1'b0;
            r_err_len    <= 1'b0;
            r_word_count <= '0;
            r_eff_len    <= '0;
            r_lane       <= 2'd0;
            r_partial    <= '0;
        end else if (load_start) begin
            // Start or restart: any partial word is thrown away, written words stay.
            r_eff_len    <= w_eff_len;
            r_err_len    <= (load_len > DEPTH_L);
            r_word_count <= '0;
            r_lane       <= 2'd0;
            r_partial    <= '0;
            if (w_eff_len == '0) begin
                r_state      <= S_DONE;
                r_load_done  <= 1'b1;
                r_byte_ready <= 1'b0;
                r_cpu_hold   <= 1'b0;
            end else begin
                r_state      <= S_LOAD;
                r_load_done  <= 1'b0;
                r_byte_ready <= 1'b1;
                r_cpu_hold   <= 1'b1;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_xfer) begin
                        if (w_last_lane) begin
                            r_lane       <= 2'd0;
                            r_partial    <= '0;
                            r_word_count <= w_wc_inc;
                            if (w_wc_inc == r_eff_len) begin
                                r_state      <= S_DONE;
                                r_byte_ready <= 1'b0;
                                r_cpu_hold   <= 1'b0;
                                r_load_done  <= 1'b1;
                            end
                        end else begin
                            r_lane <= r_lane + 2'd1;
                            case (r_lane)
                                2'd0:    r_partial[7:0]   <= byte_in;
                                2'd1:    r_partial[15:8]  <= byte_in;
                                default: r_partial[23:16] <= byte_in;
                            endcase
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Instruction store: cleared on reset, one word written per completed lane-3 byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Fetch port reads the pre-edge contents, so a same-cycle write is seen next cycle.
    assign inst       = (r_cpu_hold || w_out_range) ? 32'd0 : r_mem[w_rd_idx];
    assign byte_ready = r_byte_ready;
    assign cpu_hold   = r_cpu_hold;
    assign load_done  = r_load_done;
    assign word_count = r_word_count;
    assign err_len    = r_err_len;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: directed load scenarios followed by random loads.
// A byte-queue reference model predicts all outputs each cycle; predictions go
// into a queue that a negedge monitor drains and compares.
module tb_inst_mem_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              cpu_hold;
    logic              load_done;
    logic [ADDR_W:0]   word_count;
    logic              err_len;

    inst_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .pc         (pc),
        .inst       (inst),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .word_count (word_count),
        .err_len    (err_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard entry: which output to sample and the value it must have.
    typedef struct {
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_en = 0;

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    logic [7:0]  m_buf[$];
    bit          m_active;
    bit          m_done;
    bit          m_err;
    int          m_wc;
    int          m_eff;

    function automatic string sig_name(int s);
        case (s)
            0:       return "inst";
            1:       return "byte_ready";
            2:       return "cpu_hold";
            3:       return "load_done";
            4:       return "word_count";
            default: return "err_len";
        endcase
    endfunction

    // Monitor: compare every pending prediction against the DUT mid-cycle.
    exp_t        mon_e;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            case (mon_e.sig)
                0:       mon_act = inst;
                1:       mon_act = {31'd0, byte_ready};
                2:       mon_act = {31'd0, cpu_hold};
                3:       mon_act = {31'd0, load_done};
                4:       mon_act = {26'd0, word_count};
                default: mon_act = {31'd0, err_len};
            endcase
            n_cmp++;
            if (mon_act !== mon_e.val) begin
                n_err++;
                $display("FAIL %s @%0t pc=%h: got %h expected %h",
                         sig_name(mon_e.sig), $time, pc, mon_act, mon_e.val);
            end
        end
    end

    task automatic push(int s, logic [31:0] v);
        exp_t e;
        e.sig = s;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        m_buf.delete();
        m_active = 0;
        m_done   = 0;
        m_err    = 0;
        m_wc     = 0;
        m_eff    = 0;
    endtask

    // One clock cycle: drive inputs, predict outputs, then advance the model.
    task automatic step(bit r, bit s, int len, bit v, logic [7:0] b, logic [31:0] p);
        logic [31:0] exp_inst;
        rst        = r;
        load_start = s;
        load_len   = (ADDR_W + 1)'(len);
        byte_valid = v;
        byte_in    = b;
        pc         = p;
        if (chk_en) begin
            if (m_active || p >= 32'(DEPTH * 4)) exp_inst = 32'd0;
            else                                 exp_inst = ref_mem[p / 4];
            push(0, exp_inst);
            push(1, 32'(m_active));
            push(2, 32'(m_active));
            push(3, 32'(m_done));
            push(4, 32'(m_wc));
            push(5, 32'(m_err));
        end
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (s) begin
            m_eff = (len > DEPTH) ? DEPTH : len;
            m_err = (len > DEPTH);
            m_wc  = 0;
            m_buf.delete();
            m_done   = (m_eff == 0);
            m_active = (m_eff != 0);
        end else if (m_active && v) begin
            m_buf.push_back(b);
            if (m_buf.size() == 4) begin
                ref_mem[m_wc] = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                $display("load word %0d <= %h", m_wc, ref_mem[m_wc]);
                m_wc++;
                m_buf.delete();
                if (m_wc == m_eff) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, DEPTH * 4 - 1));
    endfunction

    task automatic stepr(bit r, bit s, int len, bit v, logic [7:0] b);
        step(r, s, len, v, b, rand_pc());
    endtask

    task automatic rd(logic [31:0] p);
        step(0, 0, 0, 0, 8'h00, p);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) rd(32'(i * 4 + $urandom_range(0, 3)));
        rd(32'(DEPTH * 4));
        rd(32'hFFFF_FFFC);
    endtask

    // Feed random bytes until the model says the load has finished.
    task automatic stream_random(int max_cycles);
        int n;
        n = 0;
        while (m_active && n < max_cycles) begin
            stepr(0, 0, 0, ($urandom_range(0, 3) != 0), 8'($urandom));
            n++;
        end
        n_cmp++;
        if (m_active) begin
            n_err++;
            $display("FAIL stream_bound: load still active after %0d cycles, required finished", n);
        end
    endtask

    logic [7:0] prog [8];
    logic [7:0] tog  [4];
    logic [7:0] rst8 [4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        prog = '{8'h14, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h1A, 8'hA0, 8'hE3};
        tog  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        rst8 = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b1; load_start = 1'b0; load_len = '0;
        byte_in = '0; byte_valid = 1'b0; pc = '0;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 8'h00, 32'd0);
        chk_en = 1;
        // Reset state
        stepr(0, 0, 0, 0, 8'h00);
        read_all();

        // Two-word program, byte_valid held high
        $display("scenario: two-word load");
        step(0, 1, 2, 0, 8'h00, 32'd0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, prog[i], 32'd0);
        step(0, 0, 0, 0, 8'h00, 32'd0);
        rd(32'd0); rd(32'd4); rd(32'd5); rd(32'd128);

        // One-word load with byte_valid toggling
        $display("scenario: toggling valid");
        stepr(0, 1, 1, 0, 8'h00);
        for (int i = 0; i < 8; i++) stepr(0, 0, 0, (i % 2 == 0), tog[i / 2]);
        stepr(0, 0, 0, 1, 8'h5A);
        rd(32'd0);

        // Restart after two bytes; the byte with load_start is dropped
        $display("scenario: restart");
        stepr(0, 1, 1, 0, 8'h00);
        stepr(0, 0, 0, 1, 8'h99);
        stepr(0, 0, 0, 1, 8'h88);
        stepr(0, 1, 1, 1, 8'h77);
        for (int i = 0; i < 4; i++) stepr(0, 0, 0, 1, rst8[i]);
        rd(32'd0); rd(32'd3);

        // Oversized length clamps to DEPTH, extra byte is refused
        $display("scenario: oversize load");
        stepr(0, 1, 40, 0, 8'h00);
        stream_random(1000);
        stepr(0, 0, 0, 1, 8'hEE);
        stepr(0, 0, 0, 1, 8'hEF);
        read_all();

        // Zero-length load completes immediately
        $display("scenario: zero length");
        stepr(0, 1, 0, 1, 8'h12);
        stepr(0, 0, 0, 1, 8'h34);
        rd(32'd8);

        // Reset after five bytes of a three-word load
        $display("scenario: reset mid-load");
        stepr(0, 1, 3, 0, 8'h00);
        for (int i = 0; i < 5; i++) stepr(0, 0, 0, 1, 8'($urandom));
        stepr(1, 0, 0, 0, 8'h00);
        read_all();

        // Random loads with occasional restarts and resets
        $display("scenario: random loads");
        for (int t = 0; t < 20; t++) begin
            stepr(0, 1, $urandom_range(0, 40), ($urandom_range(0, 1) == 1), 8'($urandom));
            for (int n = 0; n < 400 && m_active; n++) begin
                if ($urandom_range(0, 299) == 0)
                    stepr(1, 0, 0, 0, 8'h00);
                else if ($urandom_range(0, 99) == 0)
                    stepr(0, 1, $urandom_range(0, 40), 1, 8'($urandom));
                else
                    stepr(0, 0, 0, ($urandom_range(0, 3) != 0), 8'($urandom));
            end
            stream_random(800);
            for (int k = 0; k < 3; k++) stepr(0, 0, 0, 1, 8'($urandom));
            read_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
